// File: rtl/interval_timer.sv
// Memory-mapped free-running cycle timer with a sticky compare-match interrupt for cp0.
// Optional periodic auto-reload of the compare register is enabled by defining TIMER_AUTORELOAD_EN.
module interval_timer #(
    parameter int               width       = 32,
    parameter logic [width-1:0] CYCLE_ADDR  = 32'hFFFF001C,
    parameter logic [width-1:0] ACK_ADDR    = 32'hFFFF006C,
    parameter logic [width-1:0] RELOAD_ADDR = 32'hFFFF0070
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] address,
    input  logic [width-1:0] data,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [width-1:0] TimerRead,
    output logic             TimerAddress,
    output logic             TimerInterrupt,
    output logic [width-1:0] cycle
);

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    logic [width-1:0] cycle_q, cycle_d;
    logic [width-1:0] compare_q, compare_d;
    logic             pending_q, pending_d;
    logic             hit_cycle, hit_ack, hit_reload, match;

    // The reload window is only decoded when the period register exists.
    assign hit_cycle  = (address == CYCLE_ADDR);
    assign hit_ack    = (address == ACK_ADDR);
    assign hit_reload = AUTORELOAD && (address == RELOAD_ADDR);
    assign match      = (cycle_q == compare_q);

`ifdef TIMER_AUTORELOAD_EN
    logic [width-1:0] period_q, period_d;

    always_comb begin
        period_d = period_q;
        if (MemWrite && hit_reload)
            period_d = data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            period_q <= '0;
        else
            period_q <= period_d;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cycle_d   = cycle_q + width'(1);
        compare_d = compare_q;
        pending_d = pending_q;
`ifdef TIMER_AUTORELOAD_EN
        if (match && (period_q != '0))
            compare_d = compare_q + period_q;
`endif
        // A CPU store outranks the reload; the match above already used the old compare.
        if (MemWrite && hit_cycle)
            compare_d = data;
        // Set beats acknowledge when both land on the same edge.
        if (MemWrite && hit_ack)
            pending_d = 1'b0;
        if (match)
            pending_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            compare_q <= '1;
            pending_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign TimerRead      = (MemRead && hit_cycle) ? cycle_q : '0;
    assign TimerAddress   = hit_cycle || hit_ack || hit_reload;
    assign TimerInterrupt = pending_q;
    assign cycle          = cycle_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: a vector table plus hand-written multi-cycle
// sequences; expectations are queued at drive time and compared on the falling edge.
module tb_interval_timer;

    localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF001C;
    localparam logic [31:0] ACK_ADDR    = 32'hFFFF006C;
    localparam logic [31:0] RELOAD_ADDR = 32'hFFFF0070;
    localparam logic [31:0] OTHER_ADDR  = 32'hFFFF0020;
`ifdef TIMER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address, data;
    logic        MemRead, MemWrite;
    logic [31:0] TimerRead, cycle;
    logic        TimerAddress, TimerInterrupt;

    interval_timer dut (
        .clock(clock), .reset(reset), .address(address), .data(data),
        .MemRead(MemRead), .MemWrite(MemWrite), .TimerRead(TimerRead),
        .TimerAddress(TimerAddress), .TimerInterrupt(TimerInterrupt), .cycle(cycle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic [31:0] e_read;
        logic        e_taddr;
        logic        e_irq;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] read;
        logic        taddr;
        logic        irq;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cnt = 0;
    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus; the expectation is checked at the following falling edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input logic [31:0] e_read, input logic e_taddr,
                        input logic e_irq, input string nm);
        exp_t e;
        address  = a;
        data     = d;
        MemRead  = rd;
        MemWrite = wr;
        e.name   = nm;
        e.read   = e_read;
        e.taddr  = e_taddr;
        e.irq    = e_irq;
        e.cyc    = 32'(cnt);
        sb.push_back(e);
        @(posedge clock);
        #1;
        cnt++;
    endtask

    task automatic idle(input logic e_irq, input string nm);
        step(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, e_irq, nm);
    endtask

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, ".read"},  TimerRead,             mon_e.read);
            check({mon_e.name, ".taddr"}, 32'(TimerAddress),     32'(mon_e.taddr));
            check({mon_e.name, ".irq"},   32'(TimerInterrupt),   32'(mon_e.irq));
            check({mon_e.name, ".cycle"}, cycle,                 mon_e.cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{CYCLE_ADDR,  32'd0,  1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
        vecs[1] = '{CYCLE_ADDR,  32'd0,  1'b1, 1'b0, 32'd1, 1'b1, 1'b0};
        vecs[2] = '{CYCLE_ADDR,  32'd10, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0};
        vecs[3] = '{CYCLE_ADDR,  32'd0,  1'b1, 1'b0, 32'd3, 1'b1, 1'b0};
        vecs[4] = '{CYCLE_ADDR,  32'd0,  1'b1, 1'b0, 32'd4, 1'b1, 1'b0};
        vecs[5] = '{OTHER_ADDR,  32'd0,  1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
        vecs[6] = '{ACK_ADDR,    32'd0,  1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
        vecs[7] = '{RELOAD_ADDR, 32'd0,  1'b1, 1'b0, 32'd0, AUTO, 1'b0};

        reset    = 1'b1;
        address  = CYCLE_ADDR;
        data     = 32'h0;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset.cycle", cycle, 32'h0);
        check("reset.irq",   32'(TimerInterrupt), 32'h0);
        check("reset.read",  TimerRead, 32'h0);
        reset = 1'b0;
        cnt   = 0;

        // Counting loads, compare=10 stored at count 2, and address decode.
        for (int i = 0; i < 8; i++)
            step(vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].wr,
                 vecs[i].e_read, vecs[i].e_taddr, vecs[i].e_irq, $sformatf("vec%0d", i));

        // Interrupt rises one cycle after count 10 and stays sticky.
        while (cnt <= 40) idle(cnt >= 11, "sticky");
        step(ACK_ADDR, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, "ack_store");
        step(OTHER_ADDR, 32'd50, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, "other_store");
        while (cnt <= 52) idle(1'b0, "no_cmp_change");

        // Match and acknowledge on the same edge: set wins.
        step(CYCLE_ADDR, 32'd60, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "set_cmp60");
        while (cnt <= 59) idle(1'b0, "wait60");
        step(ACK_ADDR, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "ack_at_match");
        idle(1'b1, "set_wins");
        step(ACK_ADDR, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, "ack2");

        // Match and compare store on the same edge: old compare matches, new one is kept.
        step(CYCLE_ADDR, 32'd70, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "set_cmp70");
        while (cnt <= 69) idle(1'b0, "wait70");
        step(CYCLE_ADDR, 32'd80, 1'b1, 1'b1, 32'd70, 1'b1, 1'b0, "match_and_store");
        idle(1'b1, "old_cmp_match");
        step(ACK_ADDR, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, "ack3");
        while (cnt <= 80) idle(1'b0, "wait80");
        idle(1'b1, "new_cmp_written");
        step(ACK_ADDR, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, "ack4");
        idle(1'b0, "acked4");

        // Period 8, compare 96, acknowledge after each interrupt.
        step(RELOAD_ADDR, 32'd8, 1'b0, 1'b1, 32'h0, AUTO, 1'b0, "period_store");
        step(CYCLE_ADDR, 32'd96, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "set_cmp96");
        while (cnt <= 118) begin
            automatic logic ack = (cnt == 98) || (cnt == 106) || (cnt == 114);
            automatic logic irq = (cnt == 97) || (cnt == 98) ||
                                  (AUTO && ((cnt == 105) || (cnt == 106) ||
                                            (cnt == 113) || (cnt == 114)));
            step(ack ? ACK_ADDR : 32'h0, 32'h0, 1'b0, ack, 32'h0, ack, irq, "reload");
        end

        // Asynchronous reset while the interrupt is pending.
        step(CYCLE_ADDR, 32'd125, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "set_cmp125");
        while (cnt <= 127) idle(cnt >= 126, "wait125");
        address = CYCLE_ADDR;
        MemRead = 1'b1;
        reset   = 1'b1;
        #1;
        check("async_reset.irq",   32'(TimerInterrupt), 32'h0);
        check("async_reset.cycle", cycle, 32'h0);
        check("async_reset.read",  TimerRead, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("held_reset.cycle", cycle, 32'h0);
        reset = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 4; i++)
            step(CYCLE_ADDR, 32'h0, 1'b1, 1'b0, 32'(cnt), 1'b1, 1'b0, "post_reset");

        MemRead  = 1'b0;
        MemWrite = 1'b0;
        address  = 32'h0;
        @(negedge clock);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
